// File: rtl/rca32_result_stage.sv
// rca32_result_stage: registered N/Z/C/V result stage behind the ripple-carry adder,
// with a 2-entry skid buffer, a sticky overflow flag and a delivered-result counter.
module rca32_result_stage #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic             in_cout,
    input  logic             in_a_msb,
    input  logic             in_b_msb,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [3:0]       out_flags,
    output logic             sticky_v,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t         state;
    logic [W-1:0]   skid_result;
    logic [3:0]     skid_flags;
    logic [3:0]     in_flags;
    logic           in_xfer;
    logic           out_xfer;

    // For a subtract the carry-out is inverted so C reads as borrow.
    assign in_flags = {in_sum[W-1], in_sum == '0, in_cout ^ in_sub,
                       (in_a_msb == in_b_msb) && (in_sum[W-1] != in_a_msb)};
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
            skid_result <= '0;
            skid_flags  <= '0;
            sticky_v    <= 1'b0;
            out_count   <= '0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) begin
                    out_result <= in_sum;
                    out_flags  <= in_flags;
                    out_valid  <= 1'b1;
                    state      <= ONE;
                end
                ONE: if (in_xfer && out_xfer) begin
                    out_result <= in_sum;
                    out_flags  <= in_flags;
                end else if (in_xfer) begin
                    skid_result <= in_sum;
                    skid_flags  <= in_flags;
                    in_ready    <= 1'b0;
                    state       <= TWO;
                end else if (out_xfer) begin
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
                TWO: if (out_xfer) begin
                    out_result <= skid_result;
                    out_flags  <= skid_flags;
                    in_ready   <= 1'b1;
                    state      <= ONE;
                end
                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= EMPTY;
                end
            endcase
            sticky_v <= (out_xfer && out_flags[0]) ? 1'b1 : clr_sticky ? 1'b0 : sticky_v;
            if (out_xfer)
                out_count <= out_count + CNT_W'(1);
        end
    end
endmodule
